// File: rtl/led_pwm_driver.sv
// ---------------------------------------------------------------------------
// led_pwm_driver
//
// Purpose:
//   Drives the board LED pins from the PIO out_port value. A prescaled PWM
//   counter applies global brightness to the pattern. The pattern and the
//   duty request are double-buffered into shadow registers. The shadows load
//   only at a PWM period boundary, so a write can never glitch the output
//   partway through a period.
//
// Optional feature (macro LED_PWM_BLINK_EN):
//   When this macro is defined, the blink_mask port exists. Masked channels
//   are forced off during alternate groups of BLINK_PERIODS PWM periods.
//   When it is undefined, the design has no blink port and no blink logic.
//
// Ports:
//   clk            in   system clock (single domain)
//   reset          in   synchronous, active-high reset
//   led_in         in   [WIDTH]     LED pattern from the PIO out_port
//   duty           in   [PWM_BITS]  brightness request (all-ones = 100 %)
//   enable         in   global LED enable, unbuffered
//   blink_mask     in   [WIDTH]     channels that blink (LED_PWM_BLINK_EN only)
//   led_out        out  [WIDTH]     registered LED drive
//   period_start   out  one-cycle pulse when the shadow registers load
//   active_pattern out  [WIDTH]     current shadow pattern, for readback
// ---------------------------------------------------------------------------
module led_pwm_driver #(
    parameter int WIDTH         = 8,
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE      = 16,
    parameter int BLINK_PERIODS = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    led_in,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                enable,
`ifdef LED_PWM_BLINK_EN
    input  logic [WIDTH-1:0]    blink_mask,
`endif
    output logic [WIDTH-1:0]    led_out,
    output logic                period_start,
    output logic [WIDTH-1:0]    active_pattern
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("led_pwm_driver: PRESCALE must be >= 1");
    end
    if (BLINK_PERIODS < 1) begin : g_bad_blink
        $error("led_pwm_driver: BLINK_PERIODS must be >= 1");
    end

    typedef enum logic {LOAD, RUN} state_t;

    state_t              state;
    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_shadow;
    logic                tick;
    logic                boundary;
    logic [WIDTH-1:0]    on_vec;

`ifdef LED_PWM_BLINK_EN
    localparam int BLINK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_PERIODS - 1);

    logic [BLINK_W-1:0]  blink_cnt;
    logic                blink_phase;
    logic [WIDTH-1:0]    mask_shadow;
`endif

    // Decides whether the PWM gate is open for this counter position.
    // An all-ones duty is treated as a special case that means always on.
    // Otherwise, a plain "cnt < duty" compare would leave one tick dark in
    // every period.
    function automatic logic pwm_gate(input logic [PWM_BITS-1:0] cnt,
                                      input logic [PWM_BITS-1:0] dty);
        return (&dty) || (cnt < dty);
    endfunction

    assign tick     = (pre_cnt == PRE_MAX);
    assign boundary = tick && (&pwm_cnt);

    always_comb begin
        on_vec = '0;
        if (enable && pwm_gate(pwm_cnt, duty_shadow)) begin
            on_vec = active_pattern;
        end
`ifdef LED_PWM_BLINK_EN
        if (!blink_phase) begin
            on_vec = on_vec & ~mask_shadow;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= LOAD;
            pre_cnt        <= '0;
            pwm_cnt        <= '0;
            duty_shadow    <= '0;
            active_pattern <= '0;
            led_out        <= '0;
            period_start   <= 1'b0;
`ifdef LED_PWM_BLINK_EN
            blink_cnt      <= '0;
            blink_phase    <= 1'b1;
            mask_shadow    <= '0;
`endif
        end else begin
            // Output stage: the pin follows the counter and shadows one clock later.
            led_out      <= on_vec;
            period_start <= 1'b0;
            case (state)
                LOAD: begin
                    pre_cnt        <= '0;
                    pwm_cnt        <= '0;
                    active_pattern <= led_in;
                    duty_shadow    <= duty;
                    period_start   <= 1'b1;
                    state          <= RUN;
`ifdef LED_PWM_BLINK_EN
                    mask_shadow    <= blink_mask;
                    blink_cnt      <= '0;
                    blink_phase    <= 1'b1;
`endif
                end
                RUN: begin
                    pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
                    if (tick) begin
                        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
                    end
                    // Shadows load in the same cycle that pwm_cnt wraps to zero.
                    if (boundary) begin
                        active_pattern <= led_in;
                        duty_shadow    <= duty;
                        period_start   <= 1'b1;
`ifdef LED_PWM_BLINK_EN
                        mask_shadow    <= blink_mask;
                        if (blink_cnt == BLINK_MAX) begin
                            blink_cnt   <= '0;
                            blink_phase <= ~blink_phase;
                        end else begin
                            blink_cnt   <= blink_cnt + BLINK_W'(1);
                        end
`endif
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_led_pwm_driver.sv
// ---------------------------------------------------------------------------
// tb_led_pwm_driver
//
// Self-checking bench for led_pwm_driver with PRESCALE=2, PWM_BITS=4 and
// BLINK_PERIODS=2, which gives a 32-clock period. The reference model works
// from elapsed clocks since the last load. The PWM position is computed as
// (t / PRESCALE) % 16, and a boundary is detected as t % 32 == 31. Blink
// parity is taken from the number of boundaries seen. Directed literal checks
// pin the model, and a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_led_pwm_driver;

    localparam int WIDTH         = 8;
    localparam int PWM_BITS      = 4;
    localparam int PRESCALE      = 2;
    localparam int BLINK_PERIODS = 2;
    localparam int STEPS         = 1 << PWM_BITS;
    localparam int PERIOD        = PRESCALE * STEPS;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [WIDTH-1:0]    led_in = '0;
    logic [PWM_BITS-1:0] duty = '0;
    logic                enable = 1'b0;
    logic [WIDTH-1:0]    blink_mask = '0;
    logic [WIDTH-1:0]    led_out;
    logic                period_start;
    logic [WIDTH-1:0]    active_pattern;

    always #5 clk = ~clk;

    led_pwm_driver #(
        .WIDTH(WIDTH), .PWM_BITS(PWM_BITS), .PRESCALE(PRESCALE),
        .BLINK_PERIODS(BLINK_PERIODS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .led_in(led_in),
        .duty(duty),
        .enable(enable),
`ifdef LED_PWM_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .led_out(led_out),
        .period_start(period_start),
        .active_pattern(active_pattern)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit                  model_valid = 1'b0;
    bit                  m_load;
    int                  m_t;
    int                  m_nb;
    logic [WIDTH-1:0]    m_pat;
    logic [WIDTH-1:0]    m_mask;
    logic [PWM_BITS-1:0] m_duty;
    logic [WIDTH-1:0]    exp_led;
    logic                exp_ps;
    logic [WIDTH-1:0]    exp_ap;

    function automatic logic [WIDTH-1:0] model_on(input logic [WIDTH-1:0] pat,
                                                  input int dty, input int pwm,
                                                  input logic en, input bit blink_on,
                                                  input logic [WIDTH-1:0] mask);
        if (!en) return '0;
        if (dty != STEPS - 1 && pwm >= dty) return '0;
        if (!blink_on) return pat & ~mask;
        return pat;
    endfunction

    task automatic capture();
        m_pat  = led_in;
        m_duty = duty;
`ifdef LED_PWM_BLINK_EN
        m_mask = blink_mask;
`else
        m_mask = '0;
`endif
    endtask

    always @(posedge clk) begin
        int pwm;
        if (reset) begin
            m_load = 1'b1; m_t = 0; m_nb = 0;
            m_pat = '0; m_duty = '0; m_mask = '0;
            exp_led = '0; exp_ps = 1'b0; exp_ap = '0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            pwm = m_load ? 0 : (m_t / PRESCALE) % STEPS;
            exp_led = model_on(m_pat, int'(m_duty), pwm, enable,
                               ((m_nb / BLINK_PERIODS) % 2) == 0, m_mask);
            exp_ps = 1'b0;
            if (m_load) begin
                capture();
                exp_ps = 1'b1; m_load = 1'b0; m_t = 0; m_nb = 0;
            end else begin
                if (m_t % PERIOD == PERIOD - 1) begin
                    capture();
                    exp_ps = 1'b1;
                    m_nb++;
                end
                m_t++;
            end
            exp_ap = m_pat;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_valid) begin
            check("led_out", led_out, exp_led);
            check("period_start", {7'b0, period_start}, {7'b0, exp_ps});
            check("active_pattern", active_pattern, exp_ap);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; led_in = 8'hA5; duty = 4'd8; enable = 1'b1; blink_mask = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("lit_load_ps", {7'b0, period_start}, 8'h01);
        check("lit_load_ap", active_pattern, 8'hA5);
        check("lit_load_led", led_out, 8'h00);

        for (int j = 1; j <= 160; j++) begin
            @(negedge clk);
            case (j)
                1:   check("lit_p1_on_first", led_out, 8'hA5);
                2:   check("lit_p1_ps_low", {7'b0, period_start}, 8'h00);
                16:  check("lit_p1_on_last", led_out, 8'hA5);
                17:  check("lit_p1_off_first", led_out, 8'h00);
                20:  begin led_in = 8'hFF; duty = 4'd15; end
                21:  begin
                         check("lit_mid_hold_led", led_out, 8'h00);
                         check("lit_mid_hold_ap", active_pattern, 8'hA5);
                     end
                32:  begin
                         check("lit_b1_ps", {7'b0, period_start}, 8'h01);
                         check("lit_b1_ap", active_pattern, 8'hFF);
                         check("lit_b1_led", led_out, 8'h00);
                     end
                33:  check("lit_full_first", led_out, 8'hFF);
                48:  check("lit_full_mid", led_out, 8'hFF);
                63:  begin
                         check("lit_full_last", led_out, 8'hFF);
                         duty = 4'd0;
                     end
                64:  check("lit_b2_ps", {7'b0, period_start}, 8'h01);
                65:  check("lit_zero_first", led_out, 8'h00);
                80:  check("lit_zero_mid", led_out, 8'h00);
                96:  begin
                         check("lit_b3_ps", {7'b0, period_start}, 8'h01);
                         led_in = 8'h3C; duty = 4'd8;
                     end
                130: begin
                         check("lit_pre_drop", led_out, 8'h3C);
                         enable = 1'b0;
                     end
                131: check("lit_drop", led_out, 8'h00);
                135: enable = 1'b1;
                136: check("lit_resume", led_out, 8'h3C);
                160: check("lit_b5_ps", {7'b0, period_start}, 8'h01);
                default: ;
            endcase
        end

        // Mid-period reset pulse.
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("lit_rst_led", led_out, 8'h00);
        check("lit_rst_ps", {7'b0, period_start}, 8'h00);
        check("lit_rst_ap", active_pattern, 8'h00);
        reset = 1'b0; led_in = 8'h5A; duty = 4'd4;
        @(negedge clk);
        check("lit_reload_ps", {7'b0, period_start}, 8'h01);
        check("lit_reload_ap", active_pattern, 8'h5A);

`ifdef LED_PWM_BLINK_EN
        reset = 1'b1; led_in = 8'hFF; duty = 4'd15; blink_mask = 8'h0F;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int j = 1; j <= 140; j++) begin
            @(negedge clk);
            case (j)
                10:  check("lit_blink_p1", led_out, 8'hFF);
                42:  check("lit_blink_p2", led_out, 8'hFF);
                74:  check("lit_blink_p3", led_out, 8'hF0);
                106: check("lit_blink_p4", led_out, 8'hF0);
                138: check("lit_blink_p5", led_out, 8'hFF);
                default: ;
            endcase
        end
`endif

        // Randomized phase: the per-cycle compare does the checking.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) led_in = 8'($urandom);
            if ($urandom_range(0, 11) == 0) begin
                case ($urandom_range(0, 3))
                    0:       duty = 4'd0;
                    1:       duty = 4'd15;
                    default: duty = 4'($urandom);
                endcase
            end
            if ($urandom_range(0, 29) == 0) enable = ~enable;
            if ($urandom_range(0, 40) == 0) blink_mask = 8'($urandom);
            reset = ($urandom_range(0, 599) == 0);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
